// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display block: digit count, active-low
// segment patterns (bit order g,f,e,d,c,b,a) and the per-digit dwell computation.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Cycles each digit stays lit so that all digits refresh at frame_hz.
  function automatic int unsigned digit_ticks(input int unsigned clk_hz,
                                              input int unsigned frame_hz);
    return clk_hz / (NUM_DIGITS * frame_hz);
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex to active-low seven-segment (g,f,e,d,c,b,a) decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Full 16-entry lookup; every nibble value has a glyph.
  always_comb begin
    o_seg = SEG_BLANK;
    unique case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_display.sv
// Captures the Hack memory-write word and scans it as four hex digits on the
// multiplexed seven-segment display. The digit-0 decimal point flags write activity
// within the current frame. Define SEG7_BLANK_EN to blank leading-zero digits.
module seg7_display
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100000000,
  parameter int unsigned FRAME_HZ = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int unsigned DIGIT_TICKS = digit_ticks(CLK_HZ, FRAME_HZ);
  // Keep the counter at least one bit wide so DIGIT_TICKS == 1 still elaborates.
  localparam int unsigned CNT_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGIT_TICKS - 1);

  logic [15:0]      r_shown;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic             r_act;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [3:0]       r_an;

  logic             w_tick_wrap;
  logic             w_frame_end;
  logic [3:0]       w_nibble;
  logic [6:0]       w_hex_seg;
  logic [6:0]       w_seg;
  logic             w_dp;
  logic [3:0]       w_an;

  assign w_tick_wrap = (r_cnt == CNT_MAX);
  assign w_frame_end = w_tick_wrap && (r_idx == 2'd3);
  assign w_nibble    = r_shown[{r_idx, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .i_nibble (w_nibble),
    .o_seg    (w_hex_seg)
  );

  // Capture register: last write wins, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shown <= 16'h0000;
    end else if (writeM) begin
      r_shown <= outM;
    end
  end

  // Dwell counter and digit index; index advances when the counter wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else begin
      r_cnt <= w_tick_wrap ? '0 : r_cnt + 1'b1;
      if (w_tick_wrap) begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  // Activity flag: a write takes priority over the frame-boundary clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act <= 1'b0;
    end else if (writeM) begin
      r_act <= 1'b1;
    end else if (w_frame_end) begin
      r_act <= 1'b0;
    end
  end

`ifdef SEG7_BLANK_EN
  logic w_blank;
  // Digit k>0 is a leading zero when every nibble from k upward is zero.
  assign w_blank = (r_idx != 2'd0) && ((r_shown >> {r_idx, 2'b00}) == 16'h0000);
`endif

  // Next display drive derived from the current index, captured word and activity.
  always_comb begin
    w_an  = ~(4'b0001 << r_idx);
    w_seg = w_hex_seg;
    w_dp  = ~((r_idx == 2'd0) && r_act);
`ifdef SEG7_BLANK_EN
    if (w_blank) begin
      w_an  = 4'b1111;
      w_seg = SEG_BLANK;
    end
`endif
  end

  // Registered outputs so the pins change cleanly one edge after the index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= 4'b1110;
      r_seg <= SEG_0;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign seg = r_seg;
  assign dp  = r_dp;
  assign an  = r_an;

endmodule

// File: tb/tb_seg7_display.sv
// Self-checking bench for seg7_display at DIGIT_TICKS = 4 (CLK_HZ=16, FRAME_HZ=1).
// Reference model: digit index and activity are derived arithmetically from the
// number of edges since reset and the edge of the most recent write.
module tb_seg7_display;

  localparam int unsigned DT = 4;
  localparam int unsigned FR = 4 * DT;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] outM;
  logic        writeM;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  always #5 clk = ~clk;

  seg7_display #(
    .CLK_HZ   (16),
    .FRAME_HZ (1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .outM   (outM),
    .writeM (writeM),
    .seg    (seg),
    .dp     (dp),
    .an     (an)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] hex_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model state: edges since reset release, captured word, edge of last write.
  int          m_edges;
  int          m_last_write;
  logic [15:0] m_shown;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;

  task automatic model_reset();
    m_edges      = 0;
    m_last_write = -1;
    m_shown      = 16'h0000;
  endtask

  // Drive one cycle of inputs, advance a clock edge, compute the expected outputs
  // after that edge, and leave time 1 unit past the edge for sampling.
  task automatic step(input logic w, input logic [15:0] d);
    int   idx;
    bit   act;
    logic [15:0] upper;
    writeM = w;
    outM   = d;
    @(posedge clk);
    // Outputs registered at this edge reflect the state left by the previous edge.
    idx     = (m_edges / DT) % 4;
    act     = (m_last_write >= 0) && (m_last_write >= (m_edges / FR) * FR);
    upper   = m_shown >> (4 * idx);
    exp_an  = ~(4'b0001 << idx);
    exp_seg = hex_tbl[upper[3:0]];
    exp_dp  = !(idx == 0 && act);
`ifdef SEG7_BLANK_EN
    if (idx != 0 && upper == 16'h0000) begin
      exp_an  = 4'b1111;
      exp_seg = 7'b1111111;
    end
`endif
    m_edges++;
    if (w) begin
      m_shown      = d;
      m_last_write = m_edges;
    end
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    writeM = 1'b0;
    outM   = 16'h0000;
    #12;
    n_checks += 3;
    if (an !== 4'b1110) begin n_errors++; $display("FAIL reset_an got %b want 1110", an); end
    if (seg !== 7'b1000000) begin n_errors++; $display("FAIL reset_seg got %b want 1000000", seg); end
    if (dp !== 1'b1) begin n_errors++; $display("FAIL reset_dp got %b want 1", dp); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0000);
    step(1'b1, 16'h9ABC);
    step(1'b0, 16'h0000);
    // Assert reset between edges; outputs must clear with no clock edge.
    #2;
    reset = 1'b1;
    #1;
    n_checks += 3;
    if (an !== 4'b1110) begin n_errors++; $display("FAIL async_reset_an got %b want 1110", an); end
    if (seg !== 7'b1000000) begin n_errors++; $display("FAIL async_reset_seg got %b want 1000000", seg); end
    if (dp !== 1'b1) begin n_errors++; $display("FAIL async_reset_dp got %b want 1", dp); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 16'($urandom));
      n_checks += 2;
      if (an !== ~(4'b0001 << (((k - 1) / DT) % 4))) begin
        n_errors++; $display("FAIL scan_an edge %0d got %b want %b", k, an, exp_an);
      end
      if (seg !== 7'b1000000 || dp !== 1'b1) begin
        n_errors++; $display("FAIL scan_cleared edge %0d got seg %b dp %b want 1000000 1", k, seg, dp);
      end
    end
  endtask

  task automatic test_capture();
    step(1'b1, 16'h1234);
    for (int i = 0; i < 2 * FR; i++) begin
      step(1'b0, 16'h0000);
      n_checks += 3;
      if (an !== exp_an) begin n_errors++; $display("FAIL capture_an got %b want %b", an, exp_an); end
      if (seg !== exp_seg) begin n_errors++; $display("FAIL capture_seg got %b want %b", seg, exp_seg); end
      if (dp !== exp_dp) begin n_errors++; $display("FAIL capture_dp got %b want %b", dp, exp_dp); end
      if (an === 4'b1011) begin
        n_checks++;
        if (seg !== 7'b0100100) begin n_errors++; $display("FAIL capture_digit2 got %b want 0100100", seg); end
      end
    end
  endtask

  task automatic test_no_spurious();
    for (int i = 0; i < 2 * FR; i++) begin
      step(1'b0, (i % 2 == 0) ? 16'hFFFF : 16'h0000);
      n_checks += 3;
      if (an !== exp_an) begin n_errors++; $display("FAIL nowrite_an got %b want %b", an, exp_an); end
      if (seg !== exp_seg) begin n_errors++; $display("FAIL nowrite_seg got %b want %b", seg, exp_seg); end
      if (dp !== exp_dp) begin n_errors++; $display("FAIL nowrite_dp got %b want %b", dp, exp_dp); end
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 16'hAAAA);
    step(1'b1, 16'hBEEF);
    for (int i = 0; i < 2 * FR; i++) begin
      step(1'b0, 16'($urandom));
      n_checks += 3;
      if (an !== exp_an) begin n_errors++; $display("FAIL b2b_an got %b want %b", an, exp_an); end
      if (seg !== exp_seg) begin n_errors++; $display("FAIL b2b_seg got %b want %b", seg, exp_seg); end
      if (dp !== exp_dp) begin n_errors++; $display("FAIL b2b_dp got %b want %b", dp, exp_dp); end
    end
  endtask

  task automatic test_boundary_write();
    // A full idle frame first so the flag is known clear before the boundary.
    for (int i = 0; i < FR; i++) step(1'b0, 16'h0000);
    for (int i = 0; i < FR && ((m_edges + 1) % FR) != 0; i++) step(1'b0, 16'h0000);
    step(1'b1, 16'h5A5A);
    for (int i = 0; i < DT; i++) begin
      step(1'b0, 16'h0000);
      n_checks += 2;
      if (dp !== 1'b0) begin n_errors++; $display("FAIL boundary_dp got %b want 0", dp); end
      if (dp !== exp_dp || an !== exp_an) begin
        n_errors++; $display("FAIL boundary_model got dp %b an %b want %b %b", dp, an, exp_dp, exp_an);
      end
    end
  endtask

  task automatic test_blank();
    step(1'b1, 16'h0007);
    for (int i = 0; i < 2 * FR; i++) begin
      step(1'b0, 16'h0000);
      n_checks += 2;
      if (an !== exp_an) begin n_errors++; $display("FAIL blank_an got %b want %b", an, exp_an); end
      if (seg !== exp_seg) begin n_errors++; $display("FAIL blank_seg got %b want %b", seg, exp_seg); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) == 0), 16'($urandom));
      n_checks += 3;
      if (an !== exp_an) begin n_errors++; $display("FAIL random_an cyc %0d got %b want %b", i, an, exp_an); end
      if (seg !== exp_seg) begin n_errors++; $display("FAIL random_seg cyc %0d got %b want %b", i, seg, exp_seg); end
      if (dp !== exp_dp) begin n_errors++; $display("FAIL random_dp cyc %0d got %b want %b", i, dp, exp_dp); end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_no_spurious();
    test_back_to_back();
    test_boundary_write();
    test_blank();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
